// File: rtl/fruit_template_matcher.sv
`default_nettype none
// ============================================================================
// Module   : fruit_template_matcher
// Brief    : Streams a feature vector against a per-fruit template ROM and
//            accumulates the sum of absolute differences (SAD). Reports the
//            final score and a thresholded match flag with a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module fruit_template_matcher #(
   parameter int ADDR_WIDTH  = 11,
   parameter int DATA_WIDTH  = 8,
   parameter int LENGTH      = 2048,
   parameter int SCORE_WIDTH = 19,
   parameter int THRESHOLD   = 20000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   output logic                   o_busy,
   output logic [ADDR_WIDTH-1:0]  o_rom_addr,
   input  logic [DATA_WIDTH-1:0]  i_rom_rd_data,
   input  logic [DATA_WIDTH-1:0]  i_feat_data,
   input  logic                   i_feat_valid,
   output logic                   o_feat_ready,
   output logic [SCORE_WIDTH-1:0] o_score,
   output logic                   o_match,
   output logic                   o_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Index of the final element; when LENGTH == 2**ADDR_WIDTH the index
   // increment wraps to 0 on the last element, which is never used.
   localparam logic [ADDR_WIDTH-1:0]  c_LAST_IDX  = ADDR_WIDTH'(LENGTH - 1);
   localparam logic [SCORE_WIDTH-1:0] c_THRESHOLD = SCORE_WIDTH'(THRESHOLD);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [ADDR_WIDTH-1:0]    r_idx;
   logic [SCORE_WIDTH-1:0]   r_acc;
   logic [SCORE_WIDTH-1:0]   r_score;
   logic                     r_match;

   logic                     w_fire;
   logic                     w_last;
   logic [ADDR_WIDTH-1:0]    w_idx_inc;
   logic [ADDR_WIDTH-1:0]    w_rom_addr;
   logic [DATA_WIDTH:0]      w_diff;
   logic [SCORE_WIDTH-1:0]   w_sum;

   // Absolute difference of the current feature/template pair and the
   // running sum including it; one spare bit keeps the subtraction exact.
   always_comb begin
      w_diff = '0;
      if (i_feat_data >= i_rom_rd_data) begin
         w_diff = {1'b0, i_feat_data} - {1'b0, i_rom_rd_data};
      end else begin
         w_diff = {1'b0, i_rom_rd_data} - {1'b0, i_feat_data};
      end
      w_sum = r_acc + SCORE_WIDTH'(w_diff);
   end

   // Next-state decode, handshake and look-ahead ROM addressing.
   // Addressing idx+1 on a consumed element means the ROM output always
   // holds template[idx] while in RUN, so there are no bubbles.
   always_comb begin
      w_state_nxt  = r_state;
      w_fire       = 1'b0;
      w_last       = 1'b0;
      w_rom_addr   = '0;
      o_feat_ready = 1'b0;
      w_idx_inc    = r_idx + ADDR_WIDTH'(1);
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_PRIME;
            end
         end
         S_PRIME: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            o_feat_ready = 1'b1;
            w_fire       = i_feat_valid;
            w_last       = (r_idx == c_LAST_IDX);
            w_rom_addr   = w_fire ? w_idx_inc : r_idx;
            if (w_fire && w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, index, accumulator and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_acc   <= '0;
         r_score <= '0;
         r_match <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && i_start) begin
            r_idx <= '0;
            r_acc <= '0;
         end
         if (w_fire) begin
            r_idx <= w_idx_inc;
            r_acc <= w_sum;
            if (w_last) begin
               r_score <= w_sum;
               r_match <= (w_sum <= c_THRESHOLD);
            end
         end
      end
   end

   // Status outputs decoded from the registered state.
   always_comb begin
      o_busy     = (r_state != S_IDLE);
      o_done     = (r_state == S_DONE);
      o_rom_addr = w_rom_addr;
      o_score    = r_score;
      o_match    = r_match;
   end

endmodule
`default_nettype wire

// File: tb/tb_fruit_template_matcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_fruit_template_matcher
// Brief    : Directed self-checking bench for fruit_template_matcher. One
//            full-size instance (LENGTH=2048) and one short instance
//            (LENGTH=4, THRESHOLD=400), each with its own template ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fruit_template_matcher;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Full-size instance
   logic        start_a, busy_a, ready_a, match_a, done_a, valid_a;
   logic [10:0] addr_a;
   logic [7:0]  rd_a, fd_a;
   logic [18:0] score_a;
   logic [7:0]  rom_a [2048];

   // Short instance
   logic        start_b, busy_b, ready_b, match_b, done_b, valid_b;
   logic [1:0]  addr_b;
   logic [7:0]  rd_b, fd_b;
   logic [10:0] score_b;
   logic [7:0]  rom_b [4];

   int n_checks = 0;
   int n_pass   = 0;

   // Synchronous template ROMs: data is ROM[address of the previous cycle]
   always @(posedge clk) rd_a <= rom_a[addr_a];
   always @(posedge clk) rd_b <= rom_b[addr_b];

   fruit_template_matcher #(
      .ADDR_WIDTH(11), .DATA_WIDTH(8), .LENGTH(2048),
      .SCORE_WIDTH(19), .THRESHOLD(20000)
   ) dut_a (
      .clk(clk), .rst(rst), .i_start(start_a), .o_busy(busy_a),
      .o_rom_addr(addr_a), .i_rom_rd_data(rd_a), .i_feat_data(fd_a),
      .i_feat_valid(valid_a), .o_feat_ready(ready_a), .o_score(score_a),
      .o_match(match_a), .o_done(done_a)
   );

   fruit_template_matcher #(
      .ADDR_WIDTH(2), .DATA_WIDTH(8), .LENGTH(4),
      .SCORE_WIDTH(11), .THRESHOLD(400)
   ) dut_b (
      .clk(clk), .rst(rst), .i_start(start_b), .o_busy(busy_b),
      .o_rom_addr(addr_b), .i_rom_rd_data(rd_b), .i_feat_data(fd_b),
      .i_feat_valid(valid_b), .o_feat_ready(ready_b), .o_score(score_b),
      .o_match(match_b), .o_done(done_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full-size run with a constant feature value; optional reset at element rst_at
   task automatic run_a(input logic [7:0] fv, input int exp_score,
                        input logic exp_match, input int rst_at);
      int n;
      int j;
      fd_a = fv; valid_a = 1'b0; start_a = 1'b1;
      #1;
      chk("a_idle_addr", 32'(addr_a), 0);
      tick(); start_a = 1'b0; n = 1;
      #1;
      chk("a_prime_addr", 32'(addr_a), 0);
      chk("a_prime_busy", 32'(busy_a), 1);
      tick(); n = 2; j = 0;
      while (!done_a && n < 2100) begin
         valid_a = 1'b1;
         #1;
         chk("a_run_addr", 32'(addr_a), 32'((j + 1) % 2048));
         if (j == rst_at) begin
            rst = 1'b1;
            tick(); rst = 1'b0; valid_a = 1'b0;
            #1;
            chk("a_rst_busy",  32'(busy_a),  0);
            chk("a_rst_done",  32'(done_a),  0);
            chk("a_rst_score", 32'(score_a), 0);
            chk("a_rst_match", 32'(match_a), 0);
            chk("a_rst_ready", 32'(ready_a), 0);
            chk("a_rst_addr",  32'(addr_a),  0);
            repeat (3) begin
               tick();
               chk("a_rst_nodone", 32'(done_a), 0);
            end
            return;
         end
         tick(); j++; n++;
      end
      valid_a = 1'b0;
      #1;
      chk("a_done",    32'(done_a),  1);
      chk("a_latency", 32'(n),       2050);
      chk("a_score",   32'(score_a), 32'(exp_score));
      chk("a_match",   32'(match_a), 32'(exp_match));
      chk("a_ready",   32'(ready_a), 0);
      tick();
      chk("a_done_1cyc", 32'(done_a), 0);
      chk("a_idle_busy", 32'(busy_a), 0);
   endtask

   // Short run; fv holds four features (element 0 in the low byte)
   task automatic run_b(input logic [31:0] fv, input logic gaps, input logic poke,
                        input int prev_score, input int exp_score,
                        input logic exp_match, input int exp_lat);
      int n;
      int j;
      int k;
      logic v;
      valid_b = 1'b0; start_b = 1'b1;
      tick(); start_b = 1'b0; n = 1;
      #1;
      chk("b_prime_addr",  32'(addr_b),  0);
      chk("b_prime_busy",  32'(busy_b),  1);
      chk("b_prime_score", 32'(score_b), 32'(prev_score));
      tick(); n = 2; j = 0; k = 0;
      while (!done_b && n < 50) begin
         v = gaps ? ((j % 2) == 0) : 1'b1;
         valid_b = v;
         fd_b    = fv[8*k +: 8];
         start_b = poke && (j == 1);
         #1;
         chk("b_run_ready", 32'(ready_b), 1);
         chk("b_run_addr",  32'(addr_b),  32'((v ? k + 1 : k) % 4));
         tick(); start_b = 1'b0;
         if (v) k++;
         j++; n++;
      end
      valid_b = 1'b0; start_b = poke;
      #1;
      chk("b_done",    32'(done_b),  1);
      chk("b_latency", 32'(n),       32'(exp_lat));
      chk("b_score",   32'(score_b), 32'(exp_score));
      chk("b_match",   32'(match_b), 32'(exp_match));
      chk("b_ready",   32'(ready_b), 0);
      tick(); start_b = 1'b0;
      chk("b_done_1cyc", 32'(done_b), 0);
      chk("b_idle_busy", 32'(busy_b), 0);
      tick();
      chk("b_idle_busy2", 32'(busy_b),  0);
      chk("b_hold_score", 32'(score_b), 32'(exp_score));
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) rom_a[i] = 8'hFF;
      rom_b[0] = 8'd10; rom_b[1] = 8'd200; rom_b[2] = 8'd0; rom_b[3] = 8'd255;
      rst = 1'b1;
      start_a = 1'b0; valid_a = 1'b0; fd_a = 8'h00;
      start_b = 1'b0; valid_b = 1'b0; fd_b = 8'h00;
      repeat (2) tick();
      chk("rst_busy",  32'(busy_a),  0);
      chk("rst_done",  32'(done_a),  0);
      chk("rst_score", 32'(score_a), 0);
      chk("rst_match", 32'(match_a), 0);
      chk("rst_ready", 32'(ready_a), 0);
      chk("rst_addr",  32'(addr_a),  0);
      chk("rst_b_busy", 32'(busy_b), 0);
      rst = 1'b0;
      tick();

      // identical vectors, then maximum difference (no overflow)
      run_a(8'hFF, 0, 1'b1, -1);
      run_a(8'h00, 522240, 1'b0, -1);
      // reset mid-run at element 1000, then a clean run (3*2048 = 6144)
      run_a(8'hFF, 0, 1'b0, 1000);
      run_a(8'hFC, 6144, 1'b1, -1);

      // 10+100+0+255 = 365, gap-free and with alternate-cycle gaps
      run_b({8'd0, 8'd0, 8'd100, 8'd20}, 1'b0, 1'b0, 0,   365, 1'b1, 6);
      run_b({8'd0, 8'd0, 8'd100, 8'd20}, 1'b1, 1'b0, 365, 365, 1'b1, 9);
      // threshold boundary: 400 matches, 401 does not
      run_b({8'd0, 8'd35, 8'd100, 8'd20}, 1'b0, 1'b0, 365, 400, 1'b1, 6);
      run_b({8'd0, 8'd36, 8'd100, 8'd20}, 1'b0, 1'b0, 400, 401, 1'b0, 6);
      // start poked mid-RUN and in DONE: 10+145+0+255 = 410
      run_b({8'd0, 8'd0, 8'd55, 8'd20}, 1'b0, 1'b1, 401, 410, 1'b0, 6);
      // score held until the next completion
      run_b({8'd0, 8'd0, 8'd100, 8'd20}, 1'b0, 1'b0, 410, 365, 1'b1, 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
